// File: rtl/classifier_pkg.sv
// Shared types and width helpers for the classifier front end.
package classifier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Accumulator width that cannot overflow for a window of n squared pixels.
  function automatic int unsigned sum_w(input int unsigned pix_w, input int unsigned n);
    return 2 * pix_w + $clog2(n);
  endfunction

  function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction

  function automatic int unsigned ch_span(input int unsigned ch_cnt, input int unsigned w);
    return ch_cnt * w;
  endfunction

endpackage

// File: rtl/integral_ram.sv
// Result memory: one write port, one registered read port; out-of-range reads return zero.
module integral_ram #(
  parameter int unsigned DEPTH = 400,
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 75
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic          w_in_range;

  // Extra bit so DEPTH == 2**AW still compares correctly.
  assign w_in_range = ({1'b0, i_raddr} < (AW + 1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdata <= '0;
    end else if (i_rd_en) begin
      o_rdata <= w_in_range ? r_mem[i_raddr] : '0;
    end
  end

endmodule

// File: rtl/integral_window_engine.sv
// Streaming integral / squared-integral image builder for one window,
// with a synchronous random-access read-back port.
module integral_window_engine
  import classifier_pkg::*;
#(
  parameter  int unsigned PIX_W = 8,
  parameter  int unsigned CH    = 3,
  parameter  int unsigned WIN_W = 20,
  parameter  int unsigned WIN_H = 20,
  localparam int unsigned N     = WIN_W * WIN_H,
  localparam int unsigned AW    = $clog2(N),
  localparam int unsigned SUM_W = sum_w(PIX_W, N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic                  i_pix_valid,
  output logic                  o_pix_ready,
  input  logic [CH*PIX_W-1:0]   i_pix_in,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic                  i_rd_en,
  input  logic [AW-1:0]         i_rd_addr,
  output logic                  o_rd_valid,
  output logic [CH*SUM_W-1:0]   o_rd_data
);

  localparam int unsigned CW = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam int unsigned RW = (WIN_H > 1) ? $clog2(WIN_H) : 1;
  localparam int unsigned DW = ch_span(CH, SUM_W);

  state_t        r_state;
  logic          r_mode;
  logic          r_busy;
  logic          r_pix_ready;
  logic          r_done;
  logic          r_rd_valid;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_prev [WIN_W];

  logic          w_acc;
  logic          w_last;
  logic          w_rd;
  logic [DW-1:0] w_prev;
  logic [DW-1:0] w_ii;

  assign w_acc  = i_pix_valid & r_pix_ready;
  assign w_last = (r_addr == AW'(N - 1));
  assign w_rd   = i_rd_en & ~r_busy;
  assign w_prev = r_prev[r_col];

  // Per-channel row running sum plus the line-buffer entry above.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [PIX_W-1:0]   w_p;
    logic [2*PIX_W-1:0] w_sq;
    logic [SUM_W-1:0]   w_v;
    logic [SUM_W-1:0]   w_rs;
    logic [SUM_W-1:0]   w_up;
    logic [SUM_W-1:0]   r_rs;

    assign w_p  = i_pix_in[ch_lo(c, PIX_W) +: PIX_W];
    assign w_sq = (2 * PIX_W)'(w_p) * (2 * PIX_W)'(w_p);
    assign w_v  = r_mode ? SUM_W'(w_sq) : SUM_W'(w_p);
    assign w_rs = ((r_col == '0) ? '0 : r_rs) + w_v;
    assign w_up = (r_row == '0) ? '0 : w_prev[ch_lo(c, SUM_W) +: SUM_W];
    assign w_ii[ch_lo(c, SUM_W) +: SUM_W] = w_rs + w_up;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rs <= '0;
      end else if (w_acc) begin
        r_rs <= w_rs;
      end
    end
  end

  // Line buffer needs no reset: row 0 masks it.
  always_ff @(posedge clk) begin
    if (w_acc) r_prev[r_col] <= w_ii;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_pix_ready <= 1'b0;
      r_done      <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= ACCUM;
            r_mode      <= i_mode;
            r_busy      <= 1'b1;
            r_pix_ready <= 1'b1;
            r_col       <= '0;
            r_row       <= '0;
            r_addr      <= '0;
          end
        end
        ACCUM: begin
          if (w_acc) begin
            if (w_last) begin
              r_state     <= FIN;
              r_busy      <= 1'b0;
              r_pix_ready <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_addr <= r_addr + AW'(1);
              if (r_col == CW'(WIN_W - 1)) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
            end
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
    end
  end

  integral_ram #(
    .DEPTH (N),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_acc),
    .i_waddr (r_addr),
    .i_wdata (w_ii),
    .i_rd_en (w_rd),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_data)
  );

  assign o_pix_ready = r_pix_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rd_valid  = r_rd_valid;

endmodule

// File: doc/integral_window_engine.md
# integral_window_engine

Streaming integral-image engine for the face-detection classifier front end. Accepts one WIN_W×WIN_H window of multi-channel pixels in row-major order over a valid/ready handshake. Builds either the plain integral image or the squared integral image per channel into an internal result memory. Once the frame is complete, the downstream Haar-feature evaluator reads the results back through a synchronous random-access port.

## Interface
- PIX_W, 8: bits per channel per pixel
- CH, 3: channels per pixel (X, Y, Z)
- WIN_W, 20: window width in pixels
- WIN_H, 20: window height in pixels
- Derived: N = WIN_W*WIN_H; AW = $clog2(N); SUM_W = 2*PIX_W + AW
- CLK  in  1  clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  single-cycle pulse; begins a frame; honoured only in IDLE
- MODE  in  1  sampled on the START edge; 0 = sum of pixels, 1 = sum of squared pixels
- PIX_VALID  in  1  PIX_IN valid
- PIX_READY  out  1  engine accepts a pixel this cycle
- PIX_IN  in  CH*PIX_W  channel c at bits [c*PIX_W +: PIX_W], unsigned
- BUSY  out  1  high from the START edge until DONE
- DONE  out  1  one-cycle pulse when the frame is fully written
- RD_EN  in  1  read request, ignored while BUSY
- RD_ADDR  in  AW  row*WIN_W + col
- RD_VALID  out  1  RD_DATA valid
- RD_DATA  out  CH*SUM_W  channel c at bits [c*SUM_W +: SUM_W], unsigned

## Operation
- FSM states and transitions:
  - IDLE -> ACCUM on START.
  - ACCUM -> FIN on acceptance of pixel N-1.
  - FIN -> IDLE unconditionally.
- Counters: col (0..WIN_W-1) and row (0..WIN_H-1), both cleared on START. col wraps to 0 and increments row after WIN_W-1.
- A pixel is accepted when PIX_VALID && PIX_READY. PIX_READY = 1 exactly in ACCUM.
- Per channel, v = MODE ? p*p : p, zero-extended to SUM_W.
- Row running sum rs: reset to 0 at col 0, then rs += v.
- Result ii = rs + prev[col], where prev is a WIN_W-entry line buffer holding the previous row's ii. prev reads as 0 while row == 0.
- Each accepted pixel writes ii to result memory address row*WIN_W+col and to prev[col].
- SUM_W is sized so no overflow is possible. Example: 20×20, PIX_W 8, MODE 1 gives max 26,010,000 < 2^25.
- START in ACCUM or FIN is ignored, as is MODE outside the START edge.
- Result memory is never cleared. A new frame overwrites every address.
- Reads: RD_EN in IDLE returns mem[RD_ADDR] on the next cycle with RD_VALID = 1. RD_EN while BUSY yields RD_VALID = 0 and RD_DATA holds its last value. RD_ADDR ≥ N returns 0 with RD_VALID = 1.
- RESET_N low at any time:
  - FSM goes to IDLE and counters clear.
  - Memory contents are retained but undefined for use.
  - A partial frame is discarded.

## Timing
- Reset values: PIX_READY 0, BUSY 0, DONE 0, RD_VALID 0, RD_DATA 0.
- START at edge t: BUSY and PIX_READY are high from t+1.
- Throughput is one pixel per cycle with no bubbles when PIX_VALID is held high. A full frame takes N accepting cycles.
- Last pixel accepted at edge t: at t+1, DONE = 1, BUSY = 0, PIX_READY = 0 (FIN). At t+2, DONE = 0 (IDLE).
- A read issued in the DONE cycle is honoured and returns final data.
- Read latency is 1 cycle, fully pipelined: back-to-back RD_EN gives back-to-back RD_VALID.
- PIX_VALID gaps stall the counters. Results are independent of gap pattern.

## Structure
- Package classifier_pkg holds:
  - state enum {IDLE, ACCUM, FIN};
  - width function sum_w(PIX_W, N);
  - channel slice helper functions.
- Sub-module integral_ram: N×(CH*SUM_W), one write port, one synchronous read port, no reset on the array.
- The line buffer prev and the per-channel rs and adders live in the top module, generated over CH.

## Test plan
- WIN 4×4, CH 1, MODE 0, all pixels 1 -> RD_ADDR 15 = 16, RD_ADDR 5 = 4, RD_ADDR 3 = 4; DONE exactly one cycle after the 16th accept.
- Same configuration, MODE 1, all pixels 3 -> RD_ADDR 15 = 144, RD_ADDR 0 = 9.
- Default parameters, MODE 1, all channels 255 -> RD_ADDR 399 = 26,010,000 on every channel, no wrap.
- 4×4, pixel value = address (0..15), random PIX_VALID gaps -> RD_ADDR 15 = 120, RD_ADDR 5 = 10; results identical to the gap-free run.
- RESET_N pulsed after 7 accepts -> all outputs at reset values. Next START plus a 16-pixel frame of value 2 -> RD_ADDR 15 = 32.
- RD_EN and START asserted during ACCUM -> RD_VALID stays 0, frame continues unchanged, single DONE pulse.
